cpl_header_gen: RTL and testbench
=================================

// Module: cpl_header_gen
// PURPOSE
//  Completion TLP builder downstream of the AXI-to-PCIe response mapper in the master bridge.
//  Accepts one completion descriptor at a time (requester ID, tag, TC, length, lower address,
//  byte count, type, error flag) and pops it from the mapper with a one-cycle o_cpl_info_inc pulse.
//  Builds a 3DW Cpl/CplD header, hands it to the TX arbiter over valid/ready, then meters CplD payload DWs.
// PARAMETERS
//  TAG_WIDTH           10   completion tag width (10-bit tags; T9/T8 carried in DW0)
//  REQUESTER_ID_WIDTH  16   requester/completer ID width
//  PAYLOAD_LENGTH      10   Length field width in DW (0 encodes 1024)
//  TC_WIDTH            3    traffic class width
//  LOWER_ADDR_FIELD    7    lower address width
//  BYTE_COUNT_WIDTH    12   byte count width
// PORTS
//  i_clk                     in   1    clock
//  i_n_rst                   in   1    asynchronous active-low reset
//  i_completer_id            in   16   this function's ID, sampled at capture
//  i_cpl_valid               in   1    descriptor available from mapper
//  i_cpl_type                in   1    1=CplD (data), 0=Cpl (no data)
//  i_cpl_requester_id        in   16   requester ID
//  i_cpl_tag                 in   10   tag
//  i_cpl_traffic_class       in   3    TC
//  i_cpl_length              in   10   payload length in DW
//  i_cpl_lower_address       in   7    lower address
//  i_cpl_error_flag          in   1    1=unsupported request status
//  i_cpl_initial_byte_count  in   12   byte count
//  o_cpl_info_inc            out  1    one-cycle pop pulse to mapper
//  o_hdr                     out  96   header; DW0 in [95:64], DW1 [63:32], DW2 [31:0]
//  o_hdr_valid               out  1    header valid to TX arbiter
//  i_hdr_ready               in   1    TX arbiter accepts header
//  o_data_req                out  1    request one payload DW from R-data FIFO/arbiter
//  i_data_ack                in   1    payload DW transferred this cycle
//  o_busy                    out  1    state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; o_hdr=0, o_hdr_valid=0, o_data_req=0, o_cpl_info_inc=0, o_busy=0, counter=0.
//  FSM IDLE -> HDR -> (DATA if CplD) -> IDLE.
//  IDLE: if i_cpl_valid, register all descriptor fields + i_completer_id, pulse o_cpl_info_inc
//   for exactly that cycle (registered, so pulse is visible the cycle after capture edge is NOT
//   allowed: o_cpl_info_inc is combinational = IDLE & i_cpl_valid), go HDR. Else stay.
//  HDR: o_hdr_valid=1, o_hdr stable until handshake. On i_hdr_valid&i_hdr_ready: CplD -> DATA,
//   load dw_cnt = (length==0)?1024:length (11 bits); Cpl -> IDLE. No new capture while not IDLE.
//  DATA: o_data_req=1; each i_data_ack decrements dw_cnt; ack with dw_cnt==1 -> IDLE same edge.
//   i_data_ack while o_data_req=0 is ignored.
//  Header fields: DW0 Fmt=3'b010 (CplD)/3'b000 (Cpl), Type=5'b01010, [23]=tag[9], [22:20]=TC,
//   [19]=tag[8], Attr/LN/TH/TD/EP/AT=0, Length=captured length for CplD, 10'd0 for Cpl.
//   DW1 CompleterID, Status=3'b000 SC or 3'b001 UR if error flag, BCM=0, ByteCount.
//   DW2 RequesterID, tag[7:0], bit7=0, LowerAddress (forced 0 for Cpl).
//  Back-to-back: return to IDLE then capture next descriptor earliest next cycle (1 idle cycle
//   minimum between descriptors; throughput one Cpl per 2 cycles with ready held high).
//  Reset mid-operation: all state discarded, no pulse generated, outputs to reset values.
//  i_cpl_valid dropping while in HDR/DATA has no effect (descriptor already captured).
// TESTING
//  1 Cpl: type=0,tag=10'h2A5,err=0,TC=3,bc=4,len=1 -> 1 inc pulse; DW0=0x0A_B0_00_00? verify
//    Fmt=000,Type=01010,T9=1,TC=3,T8=0,Length=0; DW1 status 000; DW2 tag=0xA5, LA=0; back to IDLE.
//  2 CplD len=4, LA=7'h14, bc=16, ready high -> header then exactly 4 o_data_req acks, IDLE.
//  3 CplD len=0 -> dw_cnt 1024; exactly 1024 acks before IDLE; Length field = 10'd0.
//  4 err=1 -> status 001; hold i_hdr_ready=0 5 cycles -> o_hdr stable, no second inc pulse.
//  5 i_n_rst low during DATA with dw_cnt=3 -> all outputs 0 same cycle; after release IDLE,
//    pending i_cpl_valid captured with fresh pulse.

Source files
------------

// File: rtl/cpl_header_gen.sv
// cpl_header_gen: builds a 3DW Cpl/CplD header from a mapper descriptor and meters CplD payload DWs
// Ports:
//   i_clk, i_n_rst                 clock, asynchronous active-low reset
//   i_completer_id                 this function's ID, sampled at capture
//   i_cpl_valid / o_cpl_info_inc   descriptor available / one-cycle pop pulse
//   i_cpl_*                        descriptor fields (type, requester ID, tag, TC, length, LA, error, byte count)
//   o_hdr / o_hdr_valid / i_hdr_ready   header handshake to the TX arbiter (DW0 in [95:64])
//   o_data_req / i_data_ack        payload DW metering
//   o_busy                         any state other than IDLE
module cpl_header_gen #(
  parameter int TAG_WIDTH          = 10,
  parameter int REQUESTER_ID_WIDTH = 16,
  parameter int PAYLOAD_LENGTH     = 10,
  parameter int TC_WIDTH           = 3,
  parameter int LOWER_ADDR_FIELD   = 7,
  parameter int BYTE_COUNT_WIDTH   = 12
) (
  input  logic                          i_clk,
  input  logic                          i_n_rst,
  input  logic [REQUESTER_ID_WIDTH-1:0] i_completer_id,
  input  logic                          i_cpl_valid,
  input  logic                          i_cpl_type,
  input  logic [REQUESTER_ID_WIDTH-1:0] i_cpl_requester_id,
  input  logic [TAG_WIDTH-1:0]          i_cpl_tag,
  input  logic [TC_WIDTH-1:0]           i_cpl_traffic_class,
  input  logic [PAYLOAD_LENGTH-1:0]     i_cpl_length,
  input  logic [LOWER_ADDR_FIELD-1:0]   i_cpl_lower_address,
  input  logic                          i_cpl_error_flag,
  input  logic [BYTE_COUNT_WIDTH-1:0]   i_cpl_initial_byte_count,
  output logic                          o_cpl_info_inc,
  output logic [95:0]                   o_hdr,
  output logic                          o_hdr_valid,
  input  logic                          i_hdr_ready,
  output logic                          o_data_req,
  input  logic                          i_data_ack,
  output logic                          o_busy
);
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  localparam logic [PAYLOAD_LENGTH:0] ONE = 1;
  state_t state, state_nxt;
  logic [PAYLOAD_LENGTH:0] dw_cnt;
  logic [95:0] hdr_nxt;
  logic capture, hdr_fire, data_fire, is_cpld;
  assign capture   = state == IDLE && i_cpl_valid;
  assign hdr_fire  = o_hdr_valid && i_hdr_ready;
  assign data_fire = o_data_req && i_data_ack;
  // Fmt[1] of the captured header distinguishes CplD from Cpl, so no separate type flop is kept
  assign is_cpld   = o_hdr[94];
  always_comb begin
    hdr_nxt = {1'b0, i_cpl_type, 1'b0, 5'b01010, i_cpl_tag[9], i_cpl_traffic_class, i_cpl_tag[8], 9'd0,
               i_cpl_type ? i_cpl_length : {PAYLOAD_LENGTH{1'b0}},
               i_completer_id, 2'b00, i_cpl_error_flag, 1'b0, i_cpl_initial_byte_count,
               i_cpl_requester_id, i_cpl_tag[7:0], 1'b0,
               i_cpl_type ? i_cpl_lower_address : {LOWER_ADDR_FIELD{1'b0}}};
  end
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = capture ? HDR :
                (state == HDR && hdr_fire) ? (is_cpld ? DATA : IDLE) :
                (state == DATA && data_fire && dw_cnt == ONE) ? IDLE : state;
  end
  // The pop pulse is combinational; gating with reset keeps it silent while reset is asserted
  always_comb begin
    o_cpl_info_inc = capture && i_n_rst;
    o_hdr_valid    = state == HDR;
    o_data_req     = state == DATA;
    o_busy         = state != IDLE;
  end
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      o_hdr  <= '0;
      dw_cnt <= '0;
    end else begin
      if (capture) o_hdr <= hdr_nxt;
      // A zero Length field means 1024 DWs: the zero-detect becomes the count's MSB
      if (hdr_fire && is_cpld) dw_cnt <= {o_hdr[73:64] == 10'd0, o_hdr[73:64]};
      else if (data_fire) dw_cnt <= dw_cnt - ONE;
    end
  end
endmodule

// File: tb/tb_cpl_header_gen.sv
// tb_cpl_header_gen: table-driven and sequence checks for cpl_header_gen
module tb_cpl_header_gen;
  logic        i_clk = 0, i_n_rst = 0;
  logic [15:0] i_completer_id = 0, i_cpl_requester_id = 0;
  logic        i_cpl_valid = 0, i_cpl_type = 0, i_cpl_error_flag = 0;
  logic [9:0]  i_cpl_tag = 0, i_cpl_length = 0;
  logic [2:0]  i_cpl_traffic_class = 0;
  logic [6:0]  i_cpl_lower_address = 0;
  logic [11:0] i_cpl_initial_byte_count = 0;
  logic        o_cpl_info_inc, o_hdr_valid, i_hdr_ready = 0, o_data_req, i_data_ack = 0, o_busy;
  logic [95:0] o_hdr;
  int total = 0, bad = 0;
  typedef struct {
    logic        typ, err;
    logic [9:0]  tag, len;
    logic [2:0]  tc;
    logic [6:0]  la;
    logic [11:0] bc;
    logic [15:0] rid, cid;
    logic [95:0] exp_hdr;
    int          exp_dw;
  } vec_t;
  vec_t vecs[5];
  cpl_header_gen dut (
    .i_clk(i_clk), .i_n_rst(i_n_rst), .i_completer_id(i_completer_id), .i_cpl_valid(i_cpl_valid),
    .i_cpl_type(i_cpl_type), .i_cpl_requester_id(i_cpl_requester_id), .i_cpl_tag(i_cpl_tag),
    .i_cpl_traffic_class(i_cpl_traffic_class), .i_cpl_length(i_cpl_length),
    .i_cpl_lower_address(i_cpl_lower_address), .i_cpl_error_flag(i_cpl_error_flag),
    .i_cpl_initial_byte_count(i_cpl_initial_byte_count), .o_cpl_info_inc(o_cpl_info_inc),
    .o_hdr(o_hdr), .o_hdr_valid(o_hdr_valid), .i_hdr_ready(i_hdr_ready), .o_data_req(o_data_req),
    .i_data_ack(i_data_ack), .o_busy(o_busy)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    i_cpl_type = v.typ; i_cpl_error_flag = v.err; i_cpl_tag = v.tag; i_cpl_length = v.len;
    i_cpl_traffic_class = v.tc; i_cpl_lower_address = v.la; i_cpl_initial_byte_count = v.bc;
    i_cpl_requester_id = v.rid; i_completer_id = v.cid;
  endtask
  task automatic send(input vec_t v);
    @(negedge i_clk);
    drive(v);
    i_cpl_valid = 1;
    #1 chk("inc_pulse", 96'(o_cpl_info_inc), 96'd1);
    @(negedge i_clk);
    i_cpl_valid = 0;
    #1;
    chk("inc_once", 96'(o_cpl_info_inc), 96'd0);
    chk("hdr_valid", 96'(o_hdr_valid), 96'd1);
    chk("busy", 96'(o_busy), 96'd1);
    chk("hdr", o_hdr, v.exp_hdr);
  endtask
  task automatic drain(input int exp_dw);
    int n = 0;
    bit done = 0;
    i_hdr_ready = 1;
    i_data_ack = 1;
    for (int k = 0; k < 1100 && !done; k++) begin
      @(negedge i_clk);
      if (!o_busy) done = 1;
      else if (o_data_req) n++;
    end
    i_hdr_ready = 0;
    i_data_ack = 0;
    chk("drain_timeout", 96'(done), 96'd1);
    chk("dw_count", 96'(n), 96'(exp_dw));
    chk("idle_hdr_valid", 96'(o_hdr_valid), 96'd0);
  endtask
  initial begin
    vecs[0] = '{typ:0, err:0, tag:10'h2A5, len:10'd1, tc:3'd3, la:7'h55, bc:12'd4, rid:16'h1234,
                cid:16'hABCD, exp_hdr:96'h0AB00000_ABCD0004_1234A500, exp_dw:0};
    vecs[1] = '{typ:1, err:0, tag:10'h015, len:10'd4, tc:3'd0, la:7'h14, bc:12'd16, rid:16'h0100,
                cid:16'h0200, exp_hdr:96'h4A000004_02000010_01001514, exp_dw:4};
    vecs[2] = '{typ:1, err:0, tag:10'h100, len:10'd0, tc:3'd7, la:7'h7F, bc:12'd0, rid:16'hFFFF,
                cid:16'h0001, exp_hdr:96'h4A780000_00010000_FFFF007F, exp_dw:1024};
    vecs[3] = '{typ:0, err:1, tag:10'h3FF, len:10'd5, tc:3'd1, la:7'h03, bc:12'hFFF, rid:16'hBEEF,
                cid:16'hCAFE, exp_hdr:96'h0A980000_CAFE2FFF_BEEFFF00, exp_dw:0};
    vecs[4] = '{typ:1, err:1, tag:10'h200, len:10'd2, tc:3'd5, la:7'h41, bc:12'h008, rid:16'h0011,
                cid:16'h0022, exp_hdr:96'h4AD00002_00222008_00110041, exp_dw:2};
    i_cpl_valid = 1;
    repeat (3) @(negedge i_clk);
    chk("rst_hdr", o_hdr, 96'd0);
    chk("rst_outs", 96'({o_hdr_valid, o_data_req, o_busy, o_cpl_info_inc}), 96'd0);
    i_cpl_valid = 0;
    i_n_rst = 1;
    for (int i = 0; i < 5; i++) begin
      send(vecs[i]);
      drain(vecs[i].exp_dw);
    end
    send(vecs[3]);
    i_cpl_valid = 1;
    drive(vecs[1]);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      #1;
      chk("stall_hdr", o_hdr, vecs[3].exp_hdr);
      chk("stall_no_inc", 96'(o_cpl_info_inc), 96'd0);
      chk("stall_valid", 96'(o_hdr_valid), 96'd1);
    end
    i_cpl_valid = 0;
    drain(0);
    @(negedge i_clk);
    drive(vecs[0]);
    i_cpl_valid = 1;
    i_hdr_ready = 1;
    #1 chk("b2b_inc0", 96'(o_cpl_info_inc), 96'd1);
    @(negedge i_clk);
    #1 chk("b2b_inc1", 96'(o_cpl_info_inc), 96'd0);
    @(negedge i_clk);
    #1 chk("b2b_inc2", 96'(o_cpl_info_inc), 96'd1);
    i_cpl_valid = 0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_hdr_ready = 0;
    chk("b2b_idle", 96'(o_busy), 96'd0);
    send('{typ:1, err:0, tag:10'h001, len:10'd8, tc:3'd0, la:7'h00, bc:12'd32, rid:16'h0000,
           cid:16'h0000, exp_hdr:96'h4A000008_00000020_00000100, exp_dw:8});
    i_hdr_ready = 1;
    i_data_ack = 1;
    repeat (6) @(negedge i_clk);
    chk("pre_rst_req", 96'(o_data_req), 96'd1);
    i_hdr_ready = 0;
    i_data_ack = 0;
    drive(vecs[1]);
    i_cpl_valid = 1;
    i_n_rst = 0;
    #1;
    chk("mid_rst_outs", 96'({o_hdr_valid, o_data_req, o_busy, o_cpl_info_inc}), 96'd0);
    chk("mid_rst_hdr", o_hdr, 96'd0);
    @(negedge i_clk);
    i_n_rst = 1;
    #1 chk("post_rst_inc", 96'(o_cpl_info_inc), 96'd1);
    @(negedge i_clk);
    i_cpl_valid = 0;
    #1;
    chk("post_rst_hdr", o_hdr, vecs[1].exp_hdr);
    chk("post_rst_valid", 96'(o_hdr_valid), 96'd1);
    drain(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
